multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Parametrised successor to the multi-cycle processor control sequencer.
- Drives the one-hot stage enables (IF, ID, E, MEM, WRB) from a per-opcode-class stage path, so each instruction visits only the stages it needs.
- Adds a global stall, a memory-ready handshake with a timeout, illegal-opcode trapping and a retired-instruction counter.
- Sits beside the datapath control decoder; the decoder still produces the per-signal controls, and this block only sequences the stages.

Parameters:
- OPCODE_W, 4: opcode width. Codes >= 16 are illegal.
- MEM_TIMEOUT, 15: maximum number of MEM-state cycles waited for memReady. Legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- stall  in  1  freeze the sequencer in its current state.
- instructionCode  in  OPCODE_W  opcode from the instruction register; sampled in ID.
- memReady  in  1  data memory has completed the access.
- enIF, enID, enE, enMem, enWRB  out  1 each  stage enables, exactly one high at all times.
- stateOut  out  3  encoded current state, for debug.
- instrDone  out  1  one-cycle pulse when an instruction retires.
- illegalOp  out  1  one-cycle pulse when an illegal opcode is trapped.
- memError  out  1  sticky flag for a memory timeout.
- retiredCount  out  CNT_W  number of retired instructions; wraps.

Behaviour:
- States and encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. Encodings 5-7 are unreachable and recover to IF.
- Stage enables are a pure decode of the state register:
  - IF→enIF, ID→enID, EX→enE, MEM→enMem, WB→enWRB.
- Reset (asynchronous assert, synchronous release):
  - state=IF, so enIF=1 and all other enables are 0.
  - instrDone=0, illegalOp=0, memError=0, retiredCount=0, wait counter=0, latched class=ALU.
  - Reset asserted mid-instruction aborts the instruction immediately; no instrDone is produced.
- Opcode is latched in ID and classified as follows:
  - 0-4 ALU: IF→ID→EX→WB.
  - 5-7 LOAD: IF→ID→EX→MEM→WB.
  - 8 and 15 STORE: IF→ID→EX→MEM.
  - 9-11 BRANCH: IF→ID→EX.
  - 12-14 JUMP: IF→ID.
  - >= 16 ILLEGAL: IF→ID→IF with a one-cycle illegalOp pulse and no instrDone.
- instrDone:
  - Pulses in the cycle the sequencer leaves the instruction's final state, registered so it is high in the following IF cycle.
  - retiredCount increments in the same edge as the pulse and wraps to 0 at 2^CNT_W-1.
- Stall:
  - stall=1 holds the state, the latched class and the wait counter; no pulses are generated.
  - Stall has priority over memReady, timeout and retirement.
- MEM handshake:
  - The wait counter clears on MEM entry and increments each non-stalled MEM cycle with memReady=0.
  - memReady=1 (not stalled) exits MEM: LOAD→WB, STORE→IF with instrDone.
  - If the counter reaches MEM_TIMEOUT with memReady still 0: memError is set (sticky until reset), the instruction aborts to IF, and no instrDone is produced.
  - memReady=1 on the same cycle as the timeout is treated as success.
- memReady outside MEM is ignored.
- Latency with no stalls and memReady held at 1: ALU 4, LOAD 5, STORE 4, BRANCH 3, JUMP 2 cycles.

Decomposition:
- Shared package seq_pkg holds:
  - state encodings (S_IF..S_WB);
  - class enum (CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL);
  - opcode constants, reused from the existing constants include.
- One sub-module, opcode_classifier: combinational, OPCODE_W wide, maps an opcode to its class.
- The FSM, wait counter and retired counter live in multicycle_sequencer.

Test Plan:
- ADD (0001), memReady=1, stall=0 → enables IF,ID,EX,WB on consecutive cycles; enMem never high; instrDone in the next IF; retiredCount=1.
- LW (0101), memReady low for 3 MEM cycles then high → enMem high for 4 cycles, then WB, then IF; instrDone pulses once; memError=0.
- SW (1000), memReady held 0, MEM_TIMEOUT=15 → 15 MEM cycles, then IF; memError=1 and stays 1; retiredCount unchanged; a subsequent JMP (1100) retires with memError still 1.
- BEQ (1011) with stall=1 for 2 cycles in EX → enE high for 3 cycles, then IF; exactly one instrDone.
- OPCODE_W=5, opcode 10000 → IF, ID, then IF; illegalOp pulses once; no instrDone.
- resetN pulsed low mid-MEM of LBu (0110) → immediately enIF=1, retiredCount=0, memError=0; after release the sequence restarts cleanly from IF.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared state encodings, instruction classes and opcode boundaries for the stage sequencer.
// Combinational constants only: no latency, no flow control.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } cls_t;

    // Upper bound of each contiguous opcode range; STORE also owns the stray code 15.
    localparam logic [3:0] OP_ALU_LAST    = 4'd4;
    localparam logic [3:0] OP_LOAD_LAST   = 4'd7;
    localparam logic [3:0] OP_STORE       = 4'd8;
    localparam logic [3:0] OP_BRANCH_LAST = 4'd11;
    localparam logic [3:0] OP_STORE_ALT   = 4'd15;

endpackage

// File: rtl/opcode_classifier.sv
// Maps an opcode to the class that selects its stage path; any code >= 16 is illegal.
// Purely combinational, zero latency, no backpressure.
module opcode_classifier
    import seq_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output cls_t                cls
);

    logic [3:0] low;
    logic       high;

    assign low = opcode[3:0];

    generate
        if (OPCODE_W > 4) begin : g_wide
            assign high = |opcode[OPCODE_W-1:4];
        end else begin : g_narrow
            assign high = 1'b0;
        end
    endgenerate

    always_comb begin
        cls = CLS_ALU;
        if (high)
            cls = CLS_ILLEGAL;
        else if (low <= OP_ALU_LAST)
            cls = CLS_ALU;
        else if (low <= OP_LOAD_LAST)
            cls = CLS_LOAD;
        else if (low == OP_STORE || low == OP_STORE_ALT)
            cls = CLS_STORE;
        else if (low <= OP_BRANCH_LAST)
            cls = CLS_BRANCH;
        else
            cls = CLS_JUMP;
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle stage sequencer: walks IF/ID/EX/MEM/WB along a per-class path (2-5 cycles per instruction).
// stall freezes everything; MEM waits on memReady up to MEM_TIMEOUT cycles, then aborts with a sticky error.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                stall,
    input  logic [OPCODE_W-1:0] instructionCode,
    input  logic                memReady,
    output logic                enIF,
    output logic                enID,
    output logic                enE,
    output logic                enMem,
    output logic                enWRB,
    output logic [2:0]          stateOut,
    output logic                instrDone,
    output logic                illegalOp,
    output logic                memError,
    output logic [CNT_W-1:0]    retiredCount
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state;
    cls_t       cls_q;
    cls_t       cls_d;
    logic [7:0] wait_cnt;

    opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
        .opcode (instructionCode),
        .cls    (cls_d)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= S_IF;
            cls_q        <= CLS_ALU;
            wait_cnt     <= '0;
            instrDone    <= 1'b0;
            illegalOp    <= 1'b0;
            memError     <= 1'b0;
            retiredCount <= '0;
        end else begin
            instrDone <= 1'b0;
            illegalOp <= 1'b0;
            if (!stall) begin
                case (state)
                    S_IF: state <= S_ID;
                    S_ID: begin
                        cls_q <= cls_d;
                        case (cls_d)
                            CLS_JUMP: begin
                                state        <= S_IF;
                                instrDone    <= 1'b1;
                                retiredCount <= retiredCount + CNT_W'(1);
                            end
                            CLS_ILLEGAL: begin
                                state     <= S_IF;
                                illegalOp <= 1'b1;
                            end
                            default: state <= S_EX;
                        endcase
                    end
                    S_EX: begin
                        case (cls_q)
                            CLS_ALU: state <= S_WB;
                            CLS_LOAD, CLS_STORE: begin
                                state    <= S_MEM;
                                wait_cnt <= '0;
                            end
                            default: begin
                                state        <= S_IF;
                                instrDone    <= 1'b1;
                                retiredCount <= retiredCount + CNT_W'(1);
                            end
                        endcase
                    end
                    S_MEM: begin
                        // A ready on the timeout cycle still wins: success is checked first.
                        if (memReady) begin
                            if (cls_q == CLS_LOAD) begin
                                state <= S_WB;
                            end else begin
                                state        <= S_IF;
                                instrDone    <= 1'b1;
                                retiredCount <= retiredCount + CNT_W'(1);
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (wait_cnt + 8'd1 >= TIMEOUT) begin
                                memError <= 1'b1;
                                state    <= S_IF;
                            end
                        end
                    end
                    S_WB: begin
                        state        <= S_IF;
                        instrDone    <= 1'b1;
                        retiredCount <= retiredCount + CNT_W'(1);
                    end
                    default: state <= S_IF;
                endcase
            end
        end
    end

    always_comb begin
        enIF  = (state == S_IF);
        enID  = (state == S_ID);
        enE   = (state == S_EX);
        enMem = (state == S_MEM);
        enWRB = (state == S_WB);
    end

    assign stateOut = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed scenarios plus a randomized run against a path-table reference model.
module tb_multicycle_sequencer;

    localparam int OW     = 5;
    localparam int MEM_TO = 15;
    localparam int CW     = 4;

    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3, C_JUMP = 4, C_ILL = 5;

    logic          clock = 1'b0;
    logic          resetN = 1'b1;
    logic          stall = 1'b0;
    logic [OW-1:0] instructionCode = '0;
    logic          memReady = 1'b0;
    logic          enIF, enID, enE, enMem, enWRB;
    logic [2:0]    stateOut;
    logic          instrDone, illegalOp, memError;
    logic [CW-1:0] retiredCount;

    int tests = 0;
    int fails = 0;

    // Stage lists per class (0=IF 1=ID 2=EX 3=MEM 4=WB) and their lengths.
    int path [6][5] = '{'{0,1,2,4,0}, '{0,1,2,3,4}, '{0,1,2,3,0}, '{0,1,2,0,0}, '{0,1,0,0,0}, '{0,1,0,0,0}};
    int plen [6]    = '{4, 5, 4, 3, 2, 2};

    int m_cls, m_idx, m_wait, m_cnt;
    bit m_done, m_ill, m_err;

    multicycle_sequencer #(.OPCODE_W(OW), .MEM_TIMEOUT(MEM_TO), .CNT_W(CW)) dut (
        .clock(clock), .resetN(resetN), .stall(stall), .instructionCode(instructionCode),
        .memReady(memReady), .enIF(enIF), .enID(enID), .enE(enE), .enMem(enMem), .enWRB(enWRB),
        .stateOut(stateOut), .instrDone(instrDone), .illegalOp(illegalOp),
        .memError(memError), .retiredCount(retiredCount)
    );

    always #5 clock = ~clock;

    function automatic int classify(int op);
        if (op >= 16) return C_ILL;
        if (op <= 4) return C_ALU;
        if (op <= 7) return C_LOAD;
        if (op == 8 || op == 15) return C_STORE;
        if (op <= 11) return C_BRANCH;
        return C_JUMP;
    endfunction

    function automatic int dut_stage();
        case ({enWRB, enMem, enE, enID, enIF})
            5'b00001: return 0;
            5'b00010: return 1;
            5'b00100: return 2;
            5'b01000: return 3;
            5'b10000: return 4;
            default:  return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_cls = C_ALU; m_idx = 0; m_wait = 0; m_cnt = 0;
        m_done = 0; m_ill = 0; m_err = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        m_ill  = 0;
        if (stall) return;
        if (m_idx == 1) m_cls = classify(int'(instructionCode));
        if (path[m_cls][m_idx] == 3 && !memReady) begin
            m_wait++;
            if (m_wait >= MEM_TO) begin
                m_err = 1;
                m_idx = 0;
            end
            return;
        end
        if (m_idx == plen[m_cls] - 1) begin
            m_idx = 0;
            if (m_cls == C_ILL) m_ill = 1;
            else begin
                m_done = 1;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
        end else begin
            m_idx++;
            if (path[m_cls][m_idx] == 3) m_wait = 0;
        end
    endtask

    // One clock: inputs already driven, model advances on the same edge, sample 1ns later.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 resetN = 1'b0;
        @(posedge clock);
        #1;
        tests++; if (dut_stage() !== 0) begin fails++; $display("FAIL reset_stage: got %0d expected 0", dut_stage()); end
        tests++; if (stateOut !== 3'd0) begin fails++; $display("FAIL reset_stateOut: got %0d expected 0", stateOut); end
        tests++; if ({instrDone, illegalOp, memError} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {instrDone, illegalOp, memError}); end
        tests++; if (retiredCount !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", retiredCount); end
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_add();
        int exp_seq[4];
        int mem_seen = 0;
        exp_seq = '{1, 2, 4, 0};
        instructionCode = 5'd1; memReady = 1'b1; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (enMem) mem_seen++;
            tests++; if (dut_stage() !== exp_seq[i]) begin fails++; $display("FAIL add_stage%0d: got %0d expected %0d", i, dut_stage(), exp_seq[i]); end
        end
        tests++; if (mem_seen !== 0) begin fails++; $display("FAIL add_mem: got %0d expected 0", mem_seen); end
        tests++; if (instrDone !== 1'b1) begin fails++; $display("FAIL add_done: got %b expected 1", instrDone); end
        tests++; if (retiredCount !== 4'd1) begin fails++; $display("FAIL add_count: got %0d expected 1", retiredCount); end
    endtask

    task automatic test_load();
        int dones = 0;
        instructionCode = 5'd5; memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (instrDone) dones++; end
        tests++; if (dut_stage() !== 3) begin fails++; $display("FAIL load_enter_mem: got %0d expected 3", dut_stage()); end
        for (int i = 0; i < 3; i++) begin
            tick(); if (instrDone) dones++;
            tests++; if (dut_stage() !== 3) begin fails++; $display("FAIL load_wait%0d: got %0d expected 3", i, dut_stage()); end
        end
        memReady = 1'b1;
        tick(); if (instrDone) dones++;
        tests++; if (dut_stage() !== 4) begin fails++; $display("FAIL load_wb: got %0d expected 4", dut_stage()); end
        tick(); if (instrDone) dones++;
        tests++; if (dut_stage() !== 0) begin fails++; $display("FAIL load_if: got %0d expected 0", dut_stage()); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL load_dones: got %0d expected 1", dones); end
        tests++; if (retiredCount !== 4'd2) begin fails++; $display("FAIL load_count: got %0d expected 2", retiredCount); end
        tests++; if (memError !== 1'b0) begin fails++; $display("FAIL load_memerr: got %b expected 0", memError); end
    endtask

    task automatic test_store_timeout();
        int mem_cycles = 0;
        instructionCode = 5'd8; memReady = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 40; i++) begin
            if (!enMem) break;
            mem_cycles++;
            tick();
        end
        tests++; if (mem_cycles !== MEM_TO) begin fails++; $display("FAIL store_mem_cycles: got %0d expected %0d", mem_cycles, MEM_TO); end
        tests++; if (dut_stage() !== 0) begin fails++; $display("FAIL store_abort_if: got %0d expected 0", dut_stage()); end
        tests++; if ({memError, instrDone} !== 2'b10) begin fails++; $display("FAIL store_err_done: got %b expected 10", {memError, instrDone}); end
        tests++; if (retiredCount !== 4'd2) begin fails++; $display("FAIL store_count: got %0d expected 2", retiredCount); end
        instructionCode = 5'd12;
        tick(); tick();
        tests++; if ({dut_stage() == 0, instrDone, memError} !== 3'b111) begin fails++; $display("FAIL jmp_after_err: got %b expected 111", {dut_stage() == 0, instrDone, memError}); end
        tests++; if (retiredCount !== 4'd3) begin fails++; $display("FAIL jmp_count: got %0d expected 3", retiredCount); end
    endtask

    task automatic test_stall_branch();
        int ex_cycles = 0;
        int dones = 0;
        instructionCode = 5'd11; memReady = 1'b1;
        tick(); tick();
        if (enE) ex_cycles++;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin tick(); if (enE) ex_cycles++; if (instrDone) dones++; end
        stall = 1'b0;
        tick(); if (instrDone) dones++;
        tests++; if (ex_cycles !== 3) begin fails++; $display("FAIL branch_ex_cycles: got %0d expected 3", ex_cycles); end
        tests++; if (dut_stage() !== 0) begin fails++; $display("FAIL branch_if: got %0d expected 0", dut_stage()); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL branch_dones: got %0d expected 1", dones); end
        tests++; if (retiredCount !== 4'd4) begin fails++; $display("FAIL branch_count: got %0d expected 4", retiredCount); end
    endtask

    task automatic test_illegal();
        instructionCode = 5'b10000;
        tick();
        tests++; if (dut_stage() !== 1) begin fails++; $display("FAIL ill_id: got %0d expected 1", dut_stage()); end
        tick();
        tests++; if ({dut_stage() == 0, illegalOp, instrDone} !== 3'b110) begin fails++; $display("FAIL ill_trap: got %b expected 110", {dut_stage() == 0, illegalOp, instrDone}); end
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tests++; if ({dut_stage() == 0, illegalOp} !== 2'b10) begin fails++; $display("FAIL ill_once: got %b expected 10", {dut_stage() == 0, illegalOp}); end
        tests++; if (retiredCount !== 4'd4) begin fails++; $display("FAIL ill_count: got %0d expected 4", retiredCount); end
    endtask

    task automatic test_reset_mid_mem();
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 4, 0};
        instructionCode = 5'd6; memReady = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        resetN = 1'b0;
        #1;
        tests++; if ({dut_stage() == 0, stateOut} !== 4'b1000) begin fails++; $display("FAIL rst_mid_state: got %b expected 1000", {dut_stage() == 0, stateOut}); end
        tests++; if ({retiredCount, memError, instrDone} !== 6'b0) begin fails++; $display("FAIL rst_mid_regs: got %b expected 000000", {retiredCount, memError, instrDone}); end
        #1;
        resetN = 1'b1;
        model_reset();
        memReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (dut_stage() !== exp_seq[i]) begin fails++; $display("FAIL rst_restart%0d: got %0d expected %0d", i, dut_stage(), exp_seq[i]); end
        end
        tests++; if ({instrDone, retiredCount} !== 5'b10001) begin fails++; $display("FAIL rst_restart_done: got %b expected 10001", {instrDone, retiredCount}); end
    endtask

    task automatic test_random();
        int bias = 3;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) bias = int'($urandom_range(0, 4));
            if ($urandom_range(0, 399) == 0) do_reset();
            stall           = ($urandom_range(0, 4) == 0);
            instructionCode = OW'($urandom_range(0, 19));
            memReady        = (int'($urandom_range(0, 3)) < bias);
            tick();
            tests++; if (dut_stage() !== path[m_cls][m_idx]) begin fails++; $display("FAIL rnd_stage c%0d: got %0d expected %0d", c, dut_stage(), path[m_cls][m_idx]); end
            tests++; if (int'(stateOut) !== path[m_cls][m_idx]) begin fails++; $display("FAIL rnd_stateOut c%0d: got %0d expected %0d", c, stateOut, path[m_cls][m_idx]); end
            tests++; if (instrDone !== m_done) begin fails++; $display("FAIL rnd_done c%0d: got %b expected %b", c, instrDone, m_done); end
            tests++; if (illegalOp !== m_ill) begin fails++; $display("FAIL rnd_illegal c%0d: got %b expected %b", c, illegalOp, m_ill); end
            tests++; if (memError !== m_err) begin fails++; $display("FAIL rnd_memerr c%0d: got %b expected %b", c, memError, m_err); end
            tests++; if (int'(retiredCount) !== m_cnt) begin fails++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, retiredCount, m_cnt); end
        end
        stall = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_load();
        test_store_timeout();
        test_stall_branch();
        test_illegal();
        test_reset_mid_mem();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
